// File: rtl/rvfi_csr_shadow_check.sv
// rvfi_csr_shadow_check
//   Shadow-model consistency checker for one CSR on the RVFI retirement stream.
//   It keeps a shadow copy of the CSR and a per-bit "known" mask. It raises
//   sticky flags for three cases:
//     - reads that disagree with earlier retired writes,
//     - gaps or duplicates in rvfi_order, and
//     - writes that come from trapped instructions.
//   All retirement channels of one cycle are folded in index order, and only
//   the end-of-chain result is registered.

module rvfi_csr_shadow_check #(
    parameter int NRET    = 1,   // retirement channels per cycle
    parameter int CSR_W   = 64,  // CSR field width on RVFI
    parameter int MODE    = 0,   // 0: static CSR, 1: monotonic counter
    parameter int ORDER_W = 64   // width of rvfi_order per channel
) (
    input  logic                     clock,
    input  logic                     reset,       // synchronous, active-low
    input  logic                     check,       // 0 suppresses new error flags
    input  logic [NRET-1:0]          rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]  rvfi_order,
    input  logic [NRET-1:0]          rvfi_trap,
    input  logic [NRET*CSR_W-1:0]    csr_rmask,
    input  logic [NRET*CSR_W-1:0]    csr_wmask,
    input  logic [NRET*CSR_W-1:0]    csr_rdata,
    input  logic [NRET*CSR_W-1:0]    csr_wdata,
    output logic [CSR_W-1:0]         shadow,
    output logic [CSR_W-1:0]         known,
    output logic                     err_read,
    output logic                     err_order,
    output logic                     err_trapw
);

    // Registered tracking state and its next-state values.
    logic [CSR_W-1:0]   shadow_q, shadow_d;
    logic [CSR_W-1:0]   known_q, known_d;
    logic [ORDER_W-1:0] exp_order_q, exp_order_d;
    logic               seeded_q, seeded_d;
    logic               err_read_q, err_read_d;
    logic               err_order_q, err_order_d;
    logic               err_trapw_q, err_trapw_d;

    // Per-channel working values used inside the chain.
    logic [CSR_W-1:0]   ch_rmask, ch_wmask, ch_rdata, ch_wdata, ch_chk;
    logic [ORDER_W-1:0] ch_order;
    logic [ORDER_W-1:0] order_base;   // order expected for rank 0 this cycle
    logic [ORDER_W-1:0] order_rank;   // valid channels seen so far this cycle
    logic               gap_seen;     // an invalid channel precedes this one
    logic               read_bad, order_bad, trapw_bad;

    // Fold all channels of this cycle, in index order, into next-state values.
    // NOTE: blocking assignments here are deliberate. Each channel must see
    //       the shadow/known values already updated by the channels before it.
    //       Every variable is given a default first, so no latches are inferred.
    always_comb begin
        shadow_d   = shadow_q;
        known_d    = known_q;
        seeded_d   = seeded_q;
        order_base = exp_order_q;
        order_rank = '0;
        gap_seen   = 1'b0;
        read_bad   = 1'b0;
        order_bad  = 1'b0;
        trapw_bad  = 1'b0;
        ch_rmask   = '0;
        ch_wmask   = '0;
        ch_rdata   = '0;
        ch_wdata   = '0;
        ch_chk     = '0;
        ch_order   = '0;

        for (int i = 0; i < NRET; i++) begin
            ch_rmask = csr_rmask[i*CSR_W +: CSR_W];
            ch_wmask = csr_wmask[i*CSR_W +: CSR_W];
            ch_rdata = csr_rdata[i*CSR_W +: CSR_W];
            ch_wdata = csr_wdata[i*CSR_W +: CSR_W];
            ch_order = rvfi_order[i*ORDER_W +: ORDER_W];
            ch_chk   = ch_rmask & known_d;

            if (rvfi_valid[i]) begin
                // Valid channels must form a prefix of the channel vector.
                if (gap_seen) begin
                    order_bad = 1'b1;
                end
                // The first valid retirement after reset defines the sequence.
                if (!seeded_d) begin
                    order_base = ch_order;
                    seeded_d   = 1'b1;
                end
                if (ch_order != order_base + order_rank) begin
                    order_bad = 1'b1;
                end
                order_rank = order_rank + ORDER_W'(1);

                if (rvfi_trap[i]) begin
                    // A trapped instruction must not commit a CSR write.
                    if (|ch_wmask) begin
                        trapw_bad = 1'b1;
                    end
                end else begin
                    if (MODE == 0) begin
                        if (|((ch_rdata ^ shadow_d) & ch_chk)) begin
                            read_bad = 1'b1;
                        end
                    end else if (&ch_chk) begin
                        // A counter may only move forward. A read that drops
                        // from the upper half into the lower half is a wrap.
                        if ((ch_rdata < shadow_d) &&
                            !(shadow_d[CSR_W-1] && !ch_rdata[CSR_W-1])) begin
                            read_bad = 1'b1;
                        end
                        // A fully known read with no write resynchronises the
                        // counter to the value actually observed.
                        if (ch_wmask == '0) begin
                            shadow_d = ch_rdata;
                        end
                    end
                    shadow_d = (shadow_d & ~ch_wmask) | (ch_wdata & ch_wmask);
                    known_d  = known_d | ch_wmask;
                end
            end else begin
                gap_seen = 1'b1;
            end
        end

        exp_order_d = order_base + order_rank;
        err_read_d  = err_read_q  | (check & read_bad);
        err_order_d = err_order_q | (check & order_bad);
        err_trapw_d = err_trapw_q | (check & trapw_bad);
    end

    // Register tracking state. Reset takes priority over any retirement.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shadow_q    <= '0;
            known_q     <= '0;
            exp_order_q <= '0;
            seeded_q    <= 1'b0;
            err_read_q  <= 1'b0;
            err_order_q <= 1'b0;
            err_trapw_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            known_q     <= known_d;
            exp_order_q <= exp_order_d;
            seeded_q    <= seeded_d;
            err_read_q  <= err_read_d;
            err_order_q <= err_order_d;
            err_trapw_q <= err_trapw_d;
        end
    end

    assign shadow    = shadow_q;
    assign known     = known_q;
    assign err_read  = err_read_q;
    assign err_order = err_order_q;
    assign err_trapw = err_trapw_q;

endmodule

// File: tb/tb_rvfi_csr_shadow_check.sv
// Bench for rvfi_csr_shadow_check.
//   Instance u_static: NRET=2, CSR_W=32, MODE=0, ORDER_W=64.
//   Instance u_count:  NRET=1, CSR_W=32, MODE=1, ORDER_W=8.
// The driver issues directed vectors on the falling edge and queues the
// expected outputs for the following cycle. A separate monitor compares the
// queued expectations shortly after each rising edge.

module tb_rvfi_csr_shadow_check;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic chk_en;

  // Static-mode instance signals.
  logic         reset_s;
  logic [1:0]   s_valid, s_trap;
  logic [127:0] s_order;
  logic [63:0]  s_rmask, s_wmask, s_rdata, s_wdata;
  logic [31:0]  s_shadow, s_known;
  logic         s_err_read, s_err_order, s_err_trapw;

  // Counter-mode instance signals.
  logic         reset_c;
  logic [0:0]   c_valid, c_trap;
  logic [7:0]   c_order;
  logic [31:0]  c_rmask, c_wmask, c_rdata, c_wdata;
  logic [31:0]  c_shadow, c_known;
  logic         c_err_read, c_err_order, c_err_trapw;

  rvfi_csr_shadow_check #(.NRET(2), .CSR_W(32), .MODE(0), .ORDER_W(64)) u_static (
    .clock(clock), .reset(reset_s), .check(chk_en),
    .rvfi_valid(s_valid), .rvfi_order(s_order), .rvfi_trap(s_trap),
    .csr_rmask(s_rmask), .csr_wmask(s_wmask),
    .csr_rdata(s_rdata), .csr_wdata(s_wdata),
    .shadow(s_shadow), .known(s_known),
    .err_read(s_err_read), .err_order(s_err_order), .err_trapw(s_err_trapw)
  );

  rvfi_csr_shadow_check #(.NRET(1), .CSR_W(32), .MODE(1), .ORDER_W(8)) u_count (
    .clock(clock), .reset(reset_c), .check(chk_en),
    .rvfi_valid(c_valid), .rvfi_order(c_order), .rvfi_trap(c_trap),
    .csr_rmask(c_rmask), .csr_wmask(c_wmask),
    .csr_rdata(c_rdata), .csr_wdata(c_wdata),
    .shadow(c_shadow), .known(c_known),
    .err_read(c_err_read), .err_order(c_err_order), .err_trapw(c_err_trapw)
  );

  // One expected response: instance select, due cycle and output values.
  // err is {err_read, err_order, err_trapw}.
  typedef struct {
    string       name;
    int          due;
    bit          inst;
    logic [31:0] shadow;
    logic [31:0] known;
    logic [2:0]  err;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input bit on_time,
                       input logic [31:0] got_sh, input logic [31:0] exp_sh,
                       input logic [31:0] got_kn, input logic [31:0] exp_kn,
                       input logic [2:0]  got_er, input logic [2:0]  exp_er);
    bit ok;
    ok = on_time;
    if (got_sh !== exp_sh) ok = 1'b0;
    if (got_kn !== exp_kn) ok = 1'b0;
    if (got_er !== exp_er) ok = 1'b0;
    n_checks++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL %s (at %0d, on_time=%0b): got shadow=%h known=%h err=%b, expected shadow=%h known=%h err=%b",
               nm, cyc, on_time, got_sh, got_kn, got_er, exp_sh, exp_kn, exp_er);
    end
  endtask

  // Monitor: after each rising edge, compare every expectation due by now.
  always @(posedge clock) begin : monitor
    exp_t e;
    #2;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.inst) begin
        check(e.name, e.due == cyc, c_shadow, e.shadow, c_known, e.known,
              {c_err_read, c_err_order, c_err_trapw}, e.err);
      end else begin
        check(e.name, e.due == cyc, s_shadow, e.shadow, s_known, e.known,
              {s_err_read, s_err_order, s_err_trapw}, e.err);
      end
    end
  end

  task automatic idle();
    s_valid = '0; s_trap = '0; s_order = '0;
    s_rmask = '0; s_wmask = '0; s_rdata = '0; s_wdata = '0;
    c_valid = '0; c_trap = '0; c_order = '0;
    c_rmask = '0; c_wmask = '0; c_rdata = '0; c_wdata = '0;
  endtask

  task automatic set_s(input int ch, input logic [63:0] ord, input logic trap,
                       input logic [31:0] rm, input logic [31:0] wm,
                       input logic [31:0] rd, input logic [31:0] wd);
    s_valid[ch]          = 1'b1;
    s_trap[ch]           = trap;
    s_order[ch*64 +: 64] = ord;
    s_rmask[ch*32 +: 32] = rm;
    s_wmask[ch*32 +: 32] = wm;
    s_rdata[ch*32 +: 32] = rd;
    s_wdata[ch*32 +: 32] = wd;
  endtask

  task automatic set_c(input logic [7:0] ord, input logic trap,
                       input logic [31:0] rm, input logic [31:0] wm,
                       input logic [31:0] rd, input logic [31:0] wd);
    c_valid = 1'b1; c_trap = trap; c_order = ord;
    c_rmask = rm; c_wmask = wm; c_rdata = rd; c_wdata = wd;
  endtask

  // Queue the expectation for the edge that samples the current inputs,
  // then move to the next falling edge and clear the channel inputs.
  task automatic tick(input string nm, input bit inst, input logic [31:0] sh,
                      input logic [31:0] kn, input logic [2:0] er);
    exp_t e;
    e.name = nm; e.due = cyc + 1; e.inst = inst;
    e.shadow = sh; e.known = kn; e.err = er;
    sb_q.push_back(e);
    @(negedge clock);
    idle();
  endtask

  initial begin
    idle();
    chk_en  = 1'b1;
    reset_s = 1'b0;
    reset_c = 1'b0;
    @(negedge clock);
    tick("s_reset", 0, 32'h0, 32'h0, 3'b000);
    tick("c_reset", 1, 32'h0, 32'h0, 3'b000);
    reset_s = 1'b1;
    reset_c = 1'b1;

    // Static write, matching read, then a mismatching read.
    set_s(0, 0, 0, 32'h00, 32'hFF, 32'h00, 32'h5A);
    tick("s_write", 0, 32'h5A, 32'hFF, 3'b000);
    set_s(0, 1, 0, 32'hFF, 32'h00, 32'h5A, 32'h00);
    tick("s_read_ok", 0, 32'h5A, 32'hFF, 3'b000);
    set_s(0, 2, 0, 32'hFF, 32'h00, 32'h5B, 32'h00);
    tick("s_read_bad", 0, 32'h5A, 32'hFF, 3'b100);

    // Mid-stream reset overrides a retirement in the same cycle.
    reset_s = 1'b0;
    set_s(0, 3, 0, 32'h00, 32'hFF, 32'h00, 32'h77);
    tick("s_reset_mid", 0, 32'h0, 32'h0, 3'b000);
    reset_s = 1'b1;

    // Reseed at an arbitrary order; partial knowledge masks the read.
    set_s(0, 100, 0, 32'h00, 32'h0F, 32'h00, 32'h03);
    tick("s_reseed_partial", 0, 32'h03, 32'h0F, 3'b000);
    set_s(0, 101, 0, 32'hFF, 32'h00, 32'hF3, 32'h00);
    tick("s_partial_read", 0, 32'h03, 32'h0F, 3'b000);

    // Same-cycle chain: ch1 sees ch0's write.
    reset_s = 1'b0;
    tick("s_reset_2", 0, 32'h0, 32'h0, 3'b000);
    reset_s = 1'b1;
    set_s(0, 7, 0, 32'h00, 32'hFF, 32'h00, 32'h11);
    set_s(1, 8, 0, 32'hFF, 32'h00, 32'h11, 32'h00);
    tick("s_chain_ok", 0, 32'h11, 32'hFF, 3'b000);
    set_s(0, 9, 0, 32'h00, 32'hFF, 32'h00, 32'h22);
    set_s(1, 10, 0, 32'hFF, 32'h00, 32'h22, 32'h00);
    tick("s_chain_fwd", 0, 32'h22, 32'hFF, 3'b000);
    set_s(0, 11, 0, 32'h00, 32'hFF, 32'h00, 32'h11);
    set_s(1, 12, 0, 32'hFF, 32'h00, 32'h10, 32'h00);
    tick("s_chain_bad", 0, 32'h11, 32'hFF, 3'b100);

    // Order gap: 3,4 then 6.
    reset_s = 1'b0;
    tick("s_reset_3", 0, 32'h0, 32'h0, 3'b000);
    reset_s = 1'b1;
    set_s(0, 3, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    set_s(1, 4, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("s_order_34", 0, 32'h0, 32'h0, 3'b000);
    set_s(0, 6, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("s_order_gap", 0, 32'h0, 32'h0, 3'b010);

    // Non-prefix valid vector 2'b10.
    reset_s = 1'b0;
    tick("s_reset_4", 0, 32'h0, 32'h0, 3'b000);
    reset_s = 1'b1;
    set_s(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("s_nonprefix", 0, 32'h0, 32'h0, 3'b010);

    // Trapped write: flagged, shadow untouched, read on it not checked.
    reset_s = 1'b0;
    tick("s_reset_5", 0, 32'h0, 32'h0, 3'b000);
    reset_s = 1'b1;
    set_s(0, 0, 0, 32'h00, 32'hFF, 32'h00, 32'h5A);
    tick("s_pre_trap", 0, 32'h5A, 32'hFF, 3'b000);
    set_s(0, 1, 1, 32'hFF, 32'h01, 32'h00, 32'h00);
    tick("s_trapw", 0, 32'h5A, 32'hFF, 3'b001);

    // check=0: bad read is ignored, but the write still updates shadow.
    chk_en = 1'b0;
    set_s(0, 2, 0, 32'hFF, 32'hF0, 32'h00, 32'hA0);
    tick("s_check_off", 0, 32'hAA, 32'hFF, 3'b001);
    chk_en = 1'b1;

    // No valid channels: junk on the data fields changes nothing.
    s_wmask = 64'hFFFF_FFFF_FFFF_FFFF;
    s_rmask = 64'hFFFF_FFFF_FFFF_FFFF;
    tick("s_idle", 0, 32'hAA, 32'hFF, 3'b001);
    set_s(0, 3, 0, 32'hFF, 32'h00, 32'hAA, 32'h00);
    tick("s_after_off", 0, 32'hAA, 32'hFF, 3'b001);

    // Counter mode: increase ok, decrease flagged, wrap permitted.
    set_c(0, 0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h100);
    tick("c_write", 1, 32'h100, 32'hFFFF_FFFF, 3'b000);
    set_c(1, 0, 32'hFFFF_FFFF, 32'h0, 32'h105, 32'h0);
    tick("c_inc", 1, 32'h105, 32'hFFFF_FFFF, 3'b000);
    set_c(2, 0, 32'hFFFF_FFFF, 32'h0, 32'h104, 32'h0);
    tick("c_dec", 1, 32'h104, 32'hFFFF_FFFF, 3'b100);

    reset_c = 1'b0;
    tick("c_reset_2", 1, 32'h0, 32'h0, 3'b000);
    reset_c = 1'b1;
    set_c(0, 0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF0);
    tick("c_set_hi", 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 3'b000);
    set_c(1, 0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0002, 32'h0);
    tick("c_wrap", 1, 32'h0000_0002, 32'hFFFF_FFFF, 3'b000);
    set_c(2, 0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0002, 32'h0);
    tick("c_equal", 1, 32'h0000_0002, 32'hFFFF_FFFF, 3'b000);

    // Partially known counter is not checked; order wraps at FF -> 00.
    reset_c = 1'b0;
    tick("c_reset_3", 1, 32'h0, 32'h0, 3'b000);
    reset_c = 1'b1;
    set_c(8'hFE, 0, 32'h0, 32'h0000_FFFF, 32'h0, 32'h0000_0050);
    tick("c_partial_w", 1, 32'h0000_0050, 32'h0000_FFFF, 3'b000);
    set_c(8'hFF, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    tick("c_partial_r", 1, 32'h0000_0050, 32'h0000_FFFF, 3'b000);
    set_c(8'h00, 0, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0001_0000);
    tick("c_order_wrap", 1, 32'h0001_0050, 32'hFFFF_FFFF, 3'b000);
    set_c(8'h01, 0, 32'hFFFF_FFFF, 32'h0, 32'h0001_0049, 32'h0);
    tick("c_dec_after_wrap", 1, 32'h0001_0049, 32'hFFFF_FFFF, 3'b100);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clock);
    end
    while (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s: got no comparison, expected one at cycle %0d",
               sb_q[0].name, sb_q[0].due);
      void'(sb_q.pop_front());
    end

    if (n_pass == n_checks && n_checks > 0) begin
      $display("PASS: %0d/%0d checks passed", n_pass, n_checks);
    end else begin
      $display("FAIL: %0d/%0d checks passed", n_pass, n_checks);
    end
    $finish;
  end

endmodule

// File: doc/rvfi_csr_shadow_check.md
# rvfi_csr_shadow_check

Multi-channel, stateful CSR consistency checker on the RVFI retirement stream for one named CSR. It keeps a shadow copy of the CSR plus a per-bit "known" mask across retirements. It flags reads that disagree with previously retired writes, out-of-sequence `rvfi_order`, and writes from trapped instructions. It sits beside the per-instruction CSR write checks in the formal harness and also works as a simulation monitor, so all findings are exposed as sticky error outputs.

## Interface
Parameters:
- `NRET`, 1: retirement channels per cycle.
- `CSR_W`, 64: CSR field width on RVFI (32 or 64).
- `MODE`, 0: 0 = static CSR (exact read-back); 1 = monotonic counter (reads must not decrease, wrap permitted).
- `ORDER_W`, 64: width of `rvfi_order` per channel.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-low.
- `check` in 1: when 0, checks are suppressed, but shadow and order tracking still update.
- `rvfi_valid` in NRET: retirement valid per channel.
- `rvfi_order` in NRET*ORDER_W: retirement index per channel.
- `rvfi_trap` in NRET: retirement trapped.
- `csr_rmask`, `csr_wmask`, `csr_rdata`, `csr_wdata` in NRET*CSR_W each: RVFI CSR fields of the monitored CSR, channel i at bits [i*CSR_W +: CSR_W].
- `shadow` out CSR_W: current shadow value.
- `known` out CSR_W: bits of shadow established by a retired write.
- `err_read` out 1: sticky; read mismatch.
- `err_order` out 1: sticky; order gap, duplicate, or non-contiguous valid channels.
- `err_trapw` out 1: sticky; trapped retirement with nonzero `csr_wmask`.

## Operation
- Channels of one cycle are evaluated in ascending index as a combinational chain. Channel i sees the shadow and known values after channels 0..i-1 of the same cycle have been applied. Only the end-of-chain result is registered.
- Read check, for a valid, non-trapped channel with `chk = rmask & known`:
  - MODE 0: error if `(rdata ^ shadow) & chk` is nonzero.
  - MODE 1: applies only when `chk` is all-ones. Error if `rdata < shadow` unsigned, unless `shadow[CSR_W-1]==1 && rdata[CSR_W-1]==0` (wrap).
- Update, for a valid, non-trapped channel:
  - `shadow = (shadow & ~wmask) | (wdata & wmask)`
  - `known |= wmask`
  - MODE 1 additionally: on a fully-known read with no write, `shadow` takes the value of `rdata`.
- Trap: a trapped channel performs no read check and no update. Nonzero `wmask` on a trapped channel sets `err_trapw`.
- Order tracking uses register `exp_order` (ORDER_W) and a seed flag `seeded`:
  - If `seeded==0`, the first valid channel seeds the expectation with its own order.
  - Every valid channel must carry `order == exp_order + k`, where k is its rank among valid channels of that cycle. Otherwise `err_order` sets.
  - After the cycle, `exp_order` advances by the popcount of `rvfi_valid`. Arithmetic is modulo 2^ORDER_W, so wrap at all-ones is legal.
- Valid channels must form a prefix: channel i valid with some channel j<i invalid sets `err_order`.
- Error flags set only when `check==1`. Once set, they stay set until reset.

## Timing
- Reset (`reset==0` at a rising edge) clears `shadow`, `known`, `exp_order`, `seeded`, and all `err_*` to 0. This holds even mid-stream, and overrides any retirement in the same cycle.
- Latency: an offending retirement in cycle N is visible on `err_*` after edge N, i.e. in cycle N+1.
- Shadow and known updates from cycle N appear on `shadow` and `known` in cycle N+1.
- A cycle with no valid channels leaves all state unchanged.
- No handshakes: inputs are sampled every cycle and there is no backpressure.

## Test plan
- Static write then read, NRET=1, MODE=0:
  - Write `wmask=FF, wdata=5A`, then read `rmask=FF, rdata=5A` -> all `err_*`=0, `shadow=5A`, `known=FF`.
  - A following read with `rdata=5B` -> `err_read=1` in the next cycle.
- Partial knowledge, MODE=0: write `wmask=0F, wdata=03`, then read `rmask=FF, rdata=F3` -> no error, since the upper nibble is unknown.
- Same-cycle chain, NRET=2:
  - ch0 writes `wmask=FF, wdata=11`; ch1 reads `rdata=11` with orders 7,8 -> no error, `exp_order=9`.
  - Repeat with ch1 `rdata=10` -> `err_read=1`.
- Order and trap checks:
  - orders 3,4 then 6 -> `err_order=1`.
  - `rvfi_valid=2'b10` -> `err_order=1`.
  - Trapped retirement with `wmask=1` -> `err_trapw=1`, and `shadow` unchanged.
- Counter, MODE=1, CSR_W=32:
  - Write full `wdata=100`; read `rdata=105` -> ok, `shadow=105`.
  - Read `rdata=104` -> `err_read=1`.
  - Separately: `shadow=FFFFFFF0`, read `rdata=00000002` -> no error (wrap).
- Reset mid-stream: with `err_read=1` and `known=FF`, hold `reset=0` for one cycle with a valid retirement present -> all outputs 0. The next order value then reseeds with no error.
